dbus_ctrl: RTL

- Data-bus access controller sitting directly downstream of the memory stage, between its combinational request and the dbus port.
- Registers each load/store request and holds it stable on the dbus until completion.
- Returns load data and stalls the memory stage while an access is outstanding.
- Absorbs pipeline flushes that arrive mid-transaction, since the bus cannot cancel an issued request.

---
 rtl/dbus_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-bus access controller placed after the memory stage.
// Registers each load/store request, holds it stable on the dbus until
// data_ok, returns load data, and stalls the memory stage meanwhile.
// A flush that lands while a request is on the bus is absorbed by
// draining the transfer (the bus cannot cancel an issued request).
//
// Parameters:
//   TIMEOUT_CYCLES  wait cycles before timeout fires (DBUS_TIMEOUT_EN only)
//   CHECK_ALIGN     1: misaligned requests are refused and flagged
// Optional feature macro: DBUS_TIMEOUT_EN (sticky bus-timeout detector).
//
// Ports:
//   clk      clock
//   reset    asynchronous active-low reset
//   req_in   request from the memory stage (dbus_req_t)
//   advance  memory/writeback register accepts the result this cycle
//   flush    squash the current memory-stage instruction
//   dreq     registered request to the data bus
//   dresp    bus response (addr_ok ignored, data_ok completes)
//   stall    memory stage must hold
//   rdata    raw 64-bit load data
//   rvalid   rdata/completion valid for the current instruction
//   misalign current request refused (address not aligned to size)
//   timeout  sticky bus-timeout error (0 unless DBUS_TIMEOUT_EN)

package dbus_pkg;
  // size encodes log2 of the access width: 0=1B, 1=2B, 2=4B, 3=8B.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_ctrl
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   req_in,
  input  logic        advance,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        stall,
  output logic [63:0] rdata,
  output logic        rvalid,
  output logic        misalign,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t state;
  logic   aligned;

  always_comb begin
    aligned = 1'b1;
    case (req_in.size)
      3'd1:    aligned = ~req_in.addr[0];
      3'd2:    aligned = (req_in.addr[1:0] == 2'b00);
      3'd3:    aligned = (req_in.addr[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  // IDLE stalls as soon as a live request appears, so the memory stage
  // holds before the request has even reached the bus.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:        stall = req_in.valid && !flush && reset;
      BUSY, DRAIN: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  // dreq is the request register itself: the bus never sees req_in directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dreq     <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (flush) begin
            state    <= IDLE;
            rvalid   <= 1'b0;
            misalign <= 1'b0;
          end else if (state == IDLE || advance) begin
            // DONE with advance behaves like IDLE: back-to-back accept
            rvalid   <= 1'b0;
            misalign <= 1'b0;
            state    <= IDLE;
            if (req_in.valid) begin
              if (CHECK_ALIGN && !aligned) begin
                misalign <= 1'b1;
                rvalid   <= 1'b1;
                state    <= DONE;
              end else begin
                dreq  <= req_in;
                state <= BUSY;
              end
            end
          end
        end
        BUSY: begin
          if (dresp.data_ok) begin
            dreq.valid <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              if (dreq.strobe == '0) rdata <= dresp.data;
              rvalid <= 1'b1;
              state  <= DONE;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dresp.data_ok) begin
            dreq.valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DBUS_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        unused_resp;

  assign unused_resp = dresp.addr_ok;

  // Clearing while outside BUSY/DRAIN covers entry into BUSY; the
  // BUSY->DRAIN transition is cleared explicitly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (state == IDLE || state == DONE ||
                 (state == BUSY && flush && !dresp.data_ok)) begin
      wait_cnt <= '0;
    end else if (!dresp.data_ok && wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 32'd1;
      if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = dresp.addr_ok ^ (TIMEOUT_CYCLES == 0);
  assign timeout    = 1'b0;
`endif

endmodule
